// File: rtl/mem_stage_lsu.sv
// Memory stage LSU: accepts EX instructions, runs a req/ack transaction to
// data memory for loads/stores, stalls upstream while busy, and retires
// every instruction to WB as a registered one-cycle pulse.
module mem_stage_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [31:0] alu_out,
  input  logic [3:0]  reg_dest_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        wb_en,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Counter value at which an unacknowledged access gives up.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [3:0]  dest_q;
  logic        wben_q;
  logic        accept_pt, accept_mem, done_ack, done_to;

  // New instructions are only taken in IDLE; EX is ignored during ACCESS.
  assign accept_pt  = (state == IDLE) && ex_valid && !(mem_rd || mem_wr);
  assign accept_mem = (state == IDLE) && ex_valid &&  (mem_rd || mem_wr);
  // Ack takes priority over the timeout limit in the same cycle.
  assign done_ack   = (state == ACCESS) && dmem_ack;
  assign done_to    = (state == ACCESS) && !dmem_ack && (cnt == TO_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mem)           state_nxt = ACCESS;
      ACCESS:  if (done_ack || done_to)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // FSM outputs: both are pure functions of state.
  always_comb begin
    stall    = (state == ACCESS);
    dmem_req = (state == ACCESS);
  end

  // Latch the memory request at acceptance; held stable through ACCESS.
  // rd+wr together is treated as a store since we follows mem_wr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dest_q     <= '0;
      wben_q     <= 1'b0;
    end else if (accept_mem) begin
      dmem_we    <= mem_wr;
      dmem_addr  <= mem_addr;
      dmem_wdata <= mem_data;
      dest_q     <= reg_dest_in;
      wben_q     <= wb_en;
    end
  end

  // Wait counter: cleared at acceptance, counts ACCESS cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (accept_mem)                     cnt <= '0;
    else if (state == ACCESS && !dmem_ack)   cnt <= cnt + 8'd1;
  end

  // Writeback register: single-cycle pulses, data/dest hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      err      <= 1'b0;
      if (accept_pt) begin
        wb_valid <= 1'b1;
        wb_we    <= wb_en;
        wb_dest  <= reg_dest_in;
        wb_data  <= alu_out;
      end else if (done_ack) begin
        wb_valid <= 1'b1;
        wb_dest  <= dest_q;
        if (dmem_we) begin
          wb_we   <= 1'b0;
          wb_data <= dmem_wdata;
        end else begin
          wb_we   <= wben_q;
          wb_data <= dmem_rdata;
        end
      end else if (done_to) begin
        wb_valid <= 1'b1;
        wb_dest  <= dest_q;
        wb_data  <= '0;
        err      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed table, hand sequences for held
// instructions / idle ack / mid-op reset, and random ops against a
// transaction-level model.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_rd, mem_wr, wb_en, dmem_ack;
  logic [31:0] mem_addr, mem_data, alu_out, dmem_rdata;
  logic [3:0]  reg_dest_in;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_we, err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  wb_dest;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_addr(mem_addr),
    .mem_data(mem_data), .alu_out(alu_out), .reg_dest_in(reg_dest_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en(wb_en), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, wben;
    logic [31:0] addr, data, alu, rdata;
    logic [3:0]  dest;
    int          ack_at;     // ACCESS cycle carrying ack (0 = never)
    // expected results
    int          req_cycles;
    logic        x_dwe, x_wbwe, x_err;
    logic [31:0] x_wbdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_valid = 0; mem_rd = 0; mem_wr = 0; wb_en = 0; dmem_ack = 0;
    mem_addr = 0; mem_data = 0; alu_out = 0; reg_dest_in = 0; dmem_rdata = 0;
  endtask

  // Reference model: what the stage must do with one instruction, from
  // the op kind and the memory latency alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit acked = (v.ack_at >= 1) && (v.ack_at <= TO);
    if (!(v.rd || v.wr)) begin
      r.req_cycles = 0; r.x_dwe = 0; r.x_err = 0;
      r.x_wbwe = v.wben; r.x_wbdata = v.alu;
    end else begin
      r.req_cycles = acked ? v.ack_at : TO;
      r.x_dwe = v.wr;
      if (!acked)    begin r.x_err = 1; r.x_wbwe = 0;      r.x_wbdata = 0;      end
      else if (v.wr) begin r.x_err = 0; r.x_wbwe = 0;      r.x_wbdata = v.data; end
      else           begin r.x_err = 0; r.x_wbwe = v.wben; r.x_wbdata = v.rdata; end
    end
    return r;
  endfunction

  // Present one instruction, play memory, check the retirement.
  task automatic run_op(input vec_t v);
    int budget;
    ex_valid = 1; mem_rd = v.rd; mem_wr = v.wr; wb_en = v.wben;
    mem_addr = v.addr; mem_data = v.data; alu_out = v.alu; reg_dest_in = v.dest;
    step();
    for (int k = 1; k <= v.req_cycles; k++) begin
      chk("stall_access", stall, 1);
      chk("req_access", dmem_req, 1);
      chk("dmem_addr", dmem_addr, v.addr);
      chk("dmem_we", dmem_we, v.x_dwe);
      chk("dmem_wdata", dmem_wdata, v.data);
      // junk on EX while busy must be ignored
      ex_valid = 1; mem_rd = 1; mem_addr = $urandom; alu_out = $urandom;
      dmem_ack = (k == v.ack_at); dmem_rdata = (k == v.ack_at) ? v.rdata : $urandom;
      step();
    end
    idle_inputs();
    chk("stall_done", stall, 0);
    chk("req_done", dmem_req, 0);
    chk("wb_valid", wb_valid, 1);
    chk("wb_we", wb_we, v.x_wbwe);
    chk("wb_data", wb_data, v.x_wbdata);
    chk("err", err, v.x_err);
    if (!v.x_err) chk("wb_dest", wb_dest, v.dest);
    step();
    chk("wb_valid_pulse", wb_valid, 0);
    chk("err_pulse", err, 0);
    chk("stall_idle", stall, 0);
    budget = 0;
    while (stall && budget < 20) begin step(); budget++; end
    if (budget >= 20) chk("stuck_in_access", 1, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  logic [31:0] held_data;

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_stall", stall, 0);   chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbv", wb_valid, 0);  chk("rst_wbwe", wb_we, 0);
    chk("rst_dest", wb_dest, 0);  chk("rst_data", wb_data, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    step();

    //           rd wr en addr        data          alu          rdata         dst ack  req dwe wbwe err wbdata
    tbl[0] = '{0, 0, 1, 32'h0,      32'h0,        32'h1234,    32'h0,        5, 0,   0,  0,  1,   0,  32'h1234};
    tbl[1] = '{1, 0, 1, 32'h40,     32'h11,       32'h0,       32'hDEADBEEF, 3, 2,   2,  0,  1,   0,  32'hDEADBEEF};
    tbl[2] = '{0, 1, 1, 32'h80,     32'hA5A5A5A5, 32'h0,       32'h0,        7, 1,   1,  1,  0,   0,  32'hA5A5A5A5};
    tbl[3] = '{1, 0, 1, 32'h100,    32'h0,        32'h0,       32'h0,        2, 0,   4,  0,  0,   1,  32'h0};
    tbl[4] = '{1, 0, 1, 32'h104,    32'h0,        32'h0,       32'h0BAD_F00D,6, 4,   4,  0,  1,   0,  32'h0BADF00D};
    tbl[5] = '{1, 1, 1, 32'h200,    32'h5555_0000,32'h0,       32'h0,        1, 1,   1,  1,  0,   0,  32'h55550000};
    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // Store acked in its first ACCESS cycle with a pass-through held behind it.
    ex_valid = 1; mem_wr = 1; mem_addr = 32'h80; mem_data = 32'hA5A5A5A5; reg_dest_in = 4'd8;
    step();
    chk("hold_stall", stall, 1);
    ex_valid = 1; mem_wr = 0; alu_out = 32'h77; reg_dest_in = 4'd9; wb_en = 1;
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("hold_store_wbv", wb_valid, 1);
    chk("hold_store_wbwe", wb_we, 0);
    chk("hold_stall_drop", stall, 0);
    step();                                  // held pass-through accepted here
    ex_valid = 0;
    chk("hold_pt_wbv", wb_valid, 1);
    chk("hold_pt_data", wb_data, 32'h77);
    chk("hold_pt_dest", wb_dest, 4'd9);
    chk("hold_pt_we", wb_we, 1);
    step();
    chk("hold_pt_pulse", wb_valid, 0);

    // Ack while IDLE changes nothing.
    held_data = 32'h77;
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 0;
    chk("idle_ack_wbv", wb_valid, 0);
    chk("idle_ack_stall", stall, 0);
    chk("idle_ack_req", dmem_req, 0);
    chk("idle_ack_data", wb_data, held_data);

    // Reset during the 2nd ACCESS cycle of a load.
    ex_valid = 1; mem_rd = 1; mem_addr = 32'h40; reg_dest_in = 4'd3; wb_en = 1;
    step();
    idle_inputs();
    chk("rst_mid_req1", dmem_req, 1);
    step();
    chk("rst_mid_req2", dmem_req, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_req", dmem_req, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_wbv", wb_valid, 0);
    chk("rst_mid_err", err, 0);
    step();
    chk("rst_mid_wbv_hold", wb_valid, 0);
    rst_n = 1;
    step();
    chk("rst_after_wbv", wb_valid, 0);
    chk("rst_after_err", err, 0);
    rv = '{0, 0, 0, 0, 0, 32'hCAFE, 0, 4'd4, 0, 0, 0, 0, 0, 0};
    run_op(model(rv));

    // Random ops against the model.
    for (int i = 0; i < 40; i++) begin
      rv.rd = $urandom_range(0, 1); rv.wr = $urandom_range(0, 1);
      rv.wben = $urandom_range(0, 1);
      rv.addr = $urandom; rv.data = $urandom; rv.alu = $urandom; rv.rdata = $urandom;
      rv.dest = 4'($urandom_range(0, 15));
      rv.ack_at = $urandom_range(0, 6);
      run_op(model(rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory stage of the 5-stage pipeline, sitting between EX and WB.
- Consumes the EX outputs (memory address, memory data, ALU result, destination register) plus memory control bits, and runs a req/ack transaction to data memory for loads and stores.
- Stalls the pipeline upstream while a transaction is outstanding.
- Retires every instruction to WB as a registered one-cycle result; non-memory instructions pass straight through.

Parameters:
- TIMEOUT, 64, number of cycles ACCESS may wait for dmem_ack before aborting (range 1..255).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ex_valid  input  1  EX presents a valid instruction this cycle
- mem_addr  input  32  load/store address from EX
- mem_data  input  32  store data from EX
- alu_out  input  32  ALU result from EX
- reg_dest_in  input  4  destination register from EX
- mem_rd  input  1  instruction is a load
- mem_wr  input  1  instruction is a store
- wb_en  input  1  instruction writes the register file
- stall  output  1  hold EX/upstream; the instruction at EX inputs is not consumed
- dmem_req  output  1  data memory request
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  32  data memory address
- dmem_wdata  output  32  data memory write data
- dmem_ack  input  1  data memory completion; dmem_rdata valid in the same cycle
- dmem_rdata  input  32  data memory read data
- wb_valid  output  1  one-cycle pulse: an instruction retires to WB
- wb_we  output  1  register file write enable for the retiring instruction
- wb_dest  output  4  destination register
- wb_data  output  32  writeback data
- err  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset state: IDLE. All outputs 0: stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_dest, wb_data, err. Timeout counter is 0.
- FSM has two states, IDLE and ACCESS.
- stall = (state==ACCESS). It is combinational from state only and never depends on ex_valid or dmem_ack.
- dmem_req = (state==ACCESS).
- dmem_we, dmem_addr and dmem_wdata are driven from registers latched at acceptance. They are stable for the whole of ACCESS, including the ack cycle.
- IDLE, ex_valid=0: no action; wb_valid=0 next cycle.
- IDLE, ex_valid=1, mem_rd=0, mem_wr=0 (pass-through): next cycle wb_valid=1, wb_data=alu_out, wb_dest=reg_dest_in, wb_we=wb_en. Latency 1; stays in IDLE.
- IDLE, ex_valid=1, mem_rd|mem_wr (memory op): latch mem_addr, mem_data, reg_dest_in and wb_en. Set we=mem_wr, clear the counter, go to ACCESS. dmem_req rises the next cycle.
- mem_rd=1 and mem_wr=1 together: the op is treated as a store.
- ACCESS, dmem_ack=1: go to IDLE; next cycle wb_valid=1 and wb_dest=latched dest.
  - Load: wb_data=dmem_rdata (sampled in the ack cycle), wb_we=latched wb_en.
  - Store: wb_data=latched store data, wb_we=0.
  - dmem_req drops the cycle after ack.
- ACCESS, dmem_ack=0: counter increments. When the counter reaches TIMEOUT-1 with no ack:
  - Abort and go to IDLE.
  - Next cycle: wb_valid=1, wb_we=0, wb_data=0, err=1 for one cycle.
- Ack and the timeout limit in the same cycle: the ack wins and the transaction completes normally.
- While in ACCESS, ex_valid and the EX inputs are ignored. Upstream holds its next instruction under stall, and the LSU accepts it in the first IDLE cycle after returning.
- Every memory op therefore costs at least 3 cycles: accept, ACCESS with ack, and the IDLE cycle in which the next instruction is accepted.
- dmem_ack in IDLE is ignored.
- wb_valid, wb_we and err are single-cycle pulses; they are 0 on every cycle not listed above. wb_data and wb_dest hold their last value between pulses.
- Reset asserted mid-ACCESS: state returns to IDLE immediately (async), dmem_req and stall drop to 0, and no wb_valid or err pulse is produced for the aborted op.

Test Plan:
- Pass-through: ex_valid=1, alu_out=0x0000_1234, reg_dest_in=5, wb_en=1, no mem bits -> next cycle wb_valid=1, wb_data=0x1234, wb_dest=5, wb_we=1, stall never 1.
- Load with 2-cycle memory latency: mem_rd=1, mem_addr=0x40, dest=3, wb_en=1; dmem_ack with rdata=0xDEADBEEF on the 2nd ACCESS cycle -> dmem_req=1 for 2 cycles with addr=0x40, we=0; stall=1 for those 2 cycles; wb_valid=1, wb_data=0xDEADBEEF, wb_dest=3, wb_we=1 one cycle after ack.
- Store, ack in the first ACCESS cycle: mem_wr=1, addr=0x80, data=0xA5A5A5A5 -> dmem_we=1, dmem_wdata=0xA5A5A5A5 for 1 cycle; wb_valid=1 with wb_we=0; a held back-to-back pass-through is accepted the cycle after return and retires 1 cycle later.
- Timeout with TIMEOUT=4, no ack -> dmem_req high 4 cycles, then drops; err=1 and wb_valid=1 with wb_we=0, wb_data=0 for one cycle. Repeat with ack on the 4th cycle -> normal completion, err=0.
- Corner inputs: mem_rd=mem_wr=1 -> dmem_we=1 (store). dmem_ack pulsed while IDLE -> no outputs change.
- Reset mid-operation: deassert rst_n on the 2nd ACCESS cycle of a load -> dmem_req, stall, wb_valid and err are 0 immediately. After release, a pass-through is accepted normally.
